ppu_write_queue: RTL and testbench

- Frame-synchronous write buffer between the Avalon-MM slave port and the ppu table write port (chipselect/write/address/writedata).
- Queues CPU table writes during active video.
- On vertical-blank entry, commits exactly the writes queued before that edge, one per cycle, so attribute/pattern/sprite/color updates never tear mid-frame.
- Writes arriving during a commit belong to the next frame.

---
 rtl/ppu_pkg.sv | 15 +
 rtl/ppu_write_queue_if.sv | 21 ++
 rtl/wq_fifo.sv | 48 ++++
 rtl/ppu_write_queue.sv | 122 ++++++++++++
 tb/tb_ppu_write_queue.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared constants and types for the ppu table write path.
package ppu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = 16'hFFFF;

  typedef enum logic [0:0] {FILL, DRAIN} wq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
  } wq_entry_t;

endpackage

// File: rtl/ppu_write_queue_if.sv
// Avalon-MM slave write port feeding the ppu write queue.
interface ppu_write_queue_if;
  import ppu_pkg::*;

  logic              avs_chipselect;
  logic              avs_write;
  logic [ADDR_W-1:0] avs_address;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;

  modport master (
    output avs_chipselect, avs_write, avs_address, avs_writedata,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_chipselect, avs_write, avs_address, avs_writedata,
    output avs_waitrequest
  );

endinterface

// File: rtl/wq_fifo.sv
// Single-clock FIFO of address/data pairs with a registered read port.
module wq_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LOG2_DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  wq_entry_t           push_data,
  input  logic                pop,
  output wq_entry_t           rd_data,
  output logic [LOG2_DEPTH:0] level,
  output logic                full,
  output logic                empty
);

  wq_entry_t             mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;

  // Storage array carries no reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + LOG2_DEPTH'(1);
        rd_data <= mem[rd_ptr];
      end
      if (push && !pop)      level <= level + (LOG2_DEPTH+1)'(1);
      else if (pop && !push) level <= level - (LOG2_DEPTH+1)'(1);
    end
  end

  assign full  = (level == (LOG2_DEPTH+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/ppu_write_queue.sv
// Frame-synchronous write buffer: queues CPU table writes during active video
// and replays exactly the writes held at vblank entry, one per cycle.
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LOG2_DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  ppu_write_queue_if.slave    avs,
  input  logic                vblank,
  output logic                ppu_chipselect,
  output logic                ppu_write,
  output logic [ADDR_W-1:0]   ppu_address,
  output logic [DATA_W-1:0]   ppu_writedata,
  output logic [LOG2_DEPTH:0] level,
  output logic                commit_done,
  output logic                late_commit
);

  wq_state_t           state, state_next;
  logic [LOG2_DEPTH:0] snap, snap_next;
  logic                forced, forced_next;
  logic                vblank_d;
  logic                done_next, late_next, pop;
  logic                full, empty;
  logic                bus_wr, is_ctrl, data_wr, ctrl_wr, push;
  logic                force_commit, clear_late, rise;
  wq_entry_t           push_entry, rd_entry;

  // Bus decode: control-word writes bypass the queue and never stall.
  assign bus_wr       = avs.avs_chipselect && avs.avs_write;
  assign is_ctrl      = (avs.avs_address == CTRL_ADDR);
  assign data_wr      = bus_wr && !is_ctrl;
  assign ctrl_wr      = bus_wr && is_ctrl;
  assign push         = data_wr && !full;
  assign force_commit = ctrl_wr && avs.avs_writedata[0];
  assign clear_late   = ctrl_wr && avs.avs_writedata[1];
  assign rise         = vblank && !vblank_d;
  assign push_entry   = {avs.avs_address, avs.avs_writedata};

  assign avs.avs_waitrequest = data_wr && full;

  wq_fifo #(
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .rd_data   (rd_entry),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Snapshot takes the pre-edge level, so a same-edge push waits for next frame.
  always_comb begin
    state_next  = state;
    snap_next   = snap;
    forced_next = forced;
    done_next   = 1'b0;
    late_next   = late_commit && !clear_late;
    pop         = 1'b0;
    case (state)
      FILL: begin
        if (rise || force_commit) begin
          if (level != '0) begin
            snap_next   = level;
            forced_next = force_commit;
            state_next  = DRAIN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (snap == '0) begin
          done_next   = 1'b1;
          forced_next = 1'b0;
          state_next  = FILL;
        end else if (vblank || forced) begin
          pop       = !empty;
          snap_next = snap - (LOG2_DEPTH+1)'(1);
        end else begin
          late_next   = 1'b1;
          forced_next = 1'b0;
          state_next  = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      snap        <= '0;
      forced      <= 1'b0;
      vblank_d    <= 1'b0;
      commit_done <= 1'b0;
      late_commit <= 1'b0;
      ppu_write   <= 1'b0;
    end else begin
      state       <= state_next;
      snap        <= snap_next;
      forced      <= forced_next;
      vblank_d    <= vblank;
      commit_done <= done_next;
      late_commit <= late_next;
      ppu_write   <= pop;
    end
  end

  assign ppu_chipselect = ppu_write;
  assign ppu_address    = rd_entry.address;
  assign ppu_writedata  = rd_entry.writedata;

endmodule

// File: tb/tb_ppu_write_queue.sv
// Self-checking bench for ppu_write_queue: decode table, directed frame
// sequences and a randomized run against a queue-based reference model.
module tb_ppu_write_queue;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
    logic        exp_wait;
    logic [6:0]  exp_level;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        vblank;
  logic        ppu_chipselect, ppu_write, commit_done, late_commit;
  logic [15:0] ppu_address;
  logic [31:0] ppu_writedata;
  logic [6:0]  level;

  ppu_write_queue_if bus ();

  ppu_write_queue dut (
    .clk            (clk),
    .reset          (reset),
    .avs            (bus),
    .vblank         (vblank),
    .ppu_chipselect (ppu_chipselect),
    .ppu_write      (ppu_write),
    .ppu_address    (ppu_address),
    .ppu_writedata  (ppu_writedata),
    .level          (level),
    .commit_done    (commit_done),
    .late_commit    (late_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue itself plus how many entries the current frame still owes.
  ent_t        mq[$];
  int          owed;
  bit          committing, mforced, mlate, vb_prev;
  logic [15:0] m_addr;
  logic [31:0] m_data;

  int          pulses;
  bit          saw_ctrl;
  logic        last_wait, o_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    owed = 0; committing = 0; mforced = 0; mlate = 0; vb_prev = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vblank = 1'b0;
    bus.avs_chipselect = 1'b0; bus.avs_write = 1'b0;
    bus.avs_address = '0; bus.avs_writedata = '0;
    @(posedge clk); #1;
    model_clear();
    chk("rst_ppu_write", 64'(ppu_write), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_done", 64'(commit_done), 64'(0));
    chk("rst_late", 64'(late_commit), 64'(0));
    chk("rst_addr", 64'(ppu_address), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One clock: drive inputs, check waitrequest, advance model and DUT, compare outputs.
  task automatic cycle(input logic cs, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic vb);
    logic data_wr, ctrl, exp_wait, accept, frc, rise, e_write, e_done, set_late;
    ent_t ent;
    bus.avs_chipselect = cs; bus.avs_write = wr;
    bus.avs_address = a; bus.avs_writedata = d;
    vblank = vb;
    #1;
    data_wr  = cs && wr && (a != 16'hFFFF);
    ctrl     = cs && wr && (a == 16'hFFFF);
    exp_wait = data_wr && (mq.size() == 64);
    chk("waitrequest", 64'(bus.avs_waitrequest), 64'(exp_wait));
    last_wait = bus.avs_waitrequest;
    accept   = data_wr && !exp_wait;
    frc      = ctrl && d[0];
    rise     = vb && !vb_prev;
    e_write  = 0; e_done = 0; set_late = 0;
    if (!committing) begin
      if (rise || frc) begin
        if (mq.size() > 0) begin
          committing = 1; owed = mq.size(); mforced = frc;
        end else e_done = 1;
      end
    end else if (owed == 0) begin
      e_done = 1; committing = 0;
    end else if (vb || mforced) begin
      ent = mq.pop_front();
      e_write = 1; owed--;
      m_addr = ent.a; m_data = ent.d;
    end else begin
      set_late = 1; committing = 0;
    end
    mlate = (mlate && !(ctrl && d[1])) || set_late;
    if (accept) mq.push_back({a, d});
    vb_prev = vb;
    @(posedge clk); #1;
    chk("ppu_write", 64'(ppu_write), 64'(e_write));
    chk("ppu_chipselect", 64'(ppu_chipselect), 64'(e_write));
    chk("ppu_address", 64'(ppu_address), 64'(m_addr));
    chk("ppu_writedata", 64'(ppu_writedata), 64'(m_data));
    chk("level", 64'(level), 64'(mq.size()));
    chk("commit_done", 64'(commit_done), 64'(e_done));
    chk("late_commit", 64'(late_commit), 64'(mlate));
    if (ppu_write) pulses++;
    if (ppu_write && ppu_address == 16'hFFFF) saw_ctrl = 1;
    o_done = commit_done;
  endtask

  task automatic wait_done(input string name, input logic vb, input int bound);
    bit got;
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      cycle(0, 0, 16'h0, 32'h0, vb);
      if (o_done) got = 1;
    end
    chk(name, 64'(got), 64'(1));
  endtask

  vec_t        vecs [8];
  logic [15:0] t1_addr [3];

  initial begin
    bit   accepted;
    int   stalls;
    bit   vbl;
    int   vb_run, wprob, r;
    logic cs, wr;
    logic [15:0] a;
    logic [31:0] d;

    // Decode table from reset, vblank low: {cs, wr, addr, data, waitrequest, level after}.
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'h11, 1'b0, 7'd0};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 32'h12, 1'b0, 7'd0};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 32'h13, 1'b0, 7'd1};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 32'h0,  1'b0, 7'd1};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 32'h4,  1'b0, 7'd1};
    vecs[5] = '{1'b1, 1'b1, 16'h0020, 32'h15, 1'b0, 7'd2};
    vecs[6] = '{1'b0, 1'b0, 16'h0030, 32'h16, 1'b0, 7'd2};
    vecs[7] = '{1'b1, 1'b1, 16'hFFFE, 32'h17, 1'b0, 7'd3};
    t1_addr[0] = 16'h0001; t1_addr[1] = 16'h1002; t1_addr[2] = 16'h2003;
    pulses = 0; saw_ctrl = 0; last_wait = 0; o_done = 0;

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].cs, vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0);
      chk("tbl_wait", 64'(last_wait), 64'(vecs[i].exp_wait));
      chk("tbl_level", 64'(level), 64'(vecs[i].exp_level));
    end

    // Three writes committed at vblank rise: pulses at rise+2..rise+4, done at rise+5.
    do_reset();
    cycle(1, 1, 16'h0001, 32'hAAAA0001, 0);
    cycle(1, 1, 16'h1002, 32'hBBBB1002, 0);
    cycle(1, 1, 16'h2003, 32'hCCCC2003, 0);
    pulses = 0;
    cycle(0, 0, 16'h0, 32'h0, 0);
    cycle(0, 0, 16'h0, 32'h0, 0);
    chk("t1_level", 64'(level), 64'(3));
    chk("t1_nowrite", 64'(pulses), 64'(0));
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 16'h0, 32'h0, 1);
      chk("t1_wr", 64'(ppu_write), 64'(k >= 1 && k <= 3));
      if (k >= 1 && k <= 3) chk("t1_addr", 64'(ppu_address), 64'(t1_addr[k-1]));
      chk("t1_done", 64'(commit_done), 64'(k == 4));
    end
    chk("t1_level_end", 64'(level), 64'(0));
    cycle(0, 0, 16'h0, 32'h0, 0);

    // Full queue stalls a 65th write until the first pop; it is held for the next frame.
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1, 1, 16'(16'h0100 + i), $urandom, 0);
    cycle(1, 1, 16'h0BAD, 32'h65, 0);
    chk("t2_wait_full", 64'(last_wait), 64'(1));
    pulses = 0; stalls = 0; accepted = 0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      cycle(1, 1, 16'h0BAD, 32'h65, 1);
      if (last_wait) stalls++;
      else accepted = 1;
    end
    chk("t2_accepted", 64'(accepted), 64'(1));
    chk("t2_stalls", 64'(stalls), 64'(2));
    wait_done("t2_done", 1, 100);
    chk("t2_pulses", 64'(pulses), 64'(64));
    chk("t2_level", 64'(level), 64'(1));
    chk("t2_last_addr", 64'(ppu_address), 64'(16'h013F));
    cycle(0, 0, 16'h0, 32'h0, 0);

    // A write arriving mid-commit belongs to the next frame.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 16'(16'h0200 + i), $urandom, 0);
    pulses = 0;
    cycle(0, 0, 16'h0, 32'h0, 1);
    cycle(1, 1, 16'h3333, 32'h33333333, 1);
    wait_done("t3_done", 1, 20);
    chk("t3_pulses", 64'(pulses), 64'(5));
    chk("t3_level", 64'(level), 64'(1));

    // Short vblank (rise cycle + 4 drain cycles) leaves 6 behind and flags late_commit.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 1, 16'(16'h0300 + i), $urandom, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 32'h0, 1);
    cycle(0, 0, 16'h0, 32'h0, 0);
    chk("t4_pulses", 64'(pulses), 64'(4));
    chk("t4_late", 64'(late_commit), 64'(1));
    chk("t4_level", 64'(level), 64'(6));
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 32'h0, 0);
    pulses = 0;
    wait_done("t4_done", 1, 20);
    chk("t4_pulses2", 64'(pulses), 64'(6));
    chk("t4_late_held", 64'(late_commit), 64'(1));
    cycle(1, 1, 16'hFFFF, 32'h2, 0);
    chk("t4_late_clr", 64'(late_commit), 64'(0));

    // Forced commit through the control word with vblank low.
    do_reset();
    cycle(1, 1, 16'h0401, 32'h401, 0);
    cycle(1, 1, 16'h0402, 32'h402, 0);
    pulses = 0; saw_ctrl = 0;
    cycle(1, 1, 16'hFFFF, 32'h1, 0);
    chk("t5_level_ctrl", 64'(level), 64'(2));
    wait_done("t5_done", 0, 10);
    chk("t5_pulses", 64'(pulses), 64'(2));
    chk("t5_level", 64'(level), 64'(0));
    chk("t5_no_ctrl_fwd", 64'(saw_ctrl), 64'(0));

    // Asynchronous reset with 7 entries still owed.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 1, 16'(16'h0500 + i), $urandom, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 32'h0, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_write_low", 64'(ppu_write), 64'(0));
    chk("t6_level", 64'(level), 64'(0));
    do_reset();
    pulses = 0;
    cycle(0, 0, 16'h0, 32'h0, 1);
    chk("t6_done", 64'(commit_done), 64'(1));
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 32'h0, 1);
    chk("t6_pulses", 64'(pulses), 64'(0));
    cycle(0, 0, 16'h0, 32'h0, 0);

    // Randomized traffic with varying load and vblank windows.
    do_reset();
    vbl = 0; vb_run = 20; wprob = 60;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) wprob = $urandom_range(30, 95);
      if (vb_run == 0) begin
        vbl = !vbl;
        vb_run = vbl ? $urandom_range(3, 40) : $urandom_range(5, 80);
      end
      vb_run--;
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < wprob) begin
        cs = 1; wr = 1;
        if ($urandom_range(0, 15) == 0) begin
          a = 16'hFFFF;
          d = {d[31:2], ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0)};
        end else begin
          a = 16'($urandom_range(0, 16'hFFFE));
        end
      end else begin
        cs = 1'($urandom_range(0, 1)); wr = 0;
        a = 16'($urandom_range(0, 16'hFFFF));
      end
      cycle(cs, wr, a, d, vbl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
